// File: rtl/glip_uart_receive_if.sv
// Byte hand-off from the UART receiver to the control layer ingress.
// master = receiver (drives data/valid), slave = consumer (drives ready).
interface glip_uart_receive_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/glip_uart_receive.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, one-entry holding register.
// Define GLIP_UART_RX_PARITY_EN for 8E1 framing with an error_parity output.
module glip_uart_receive #(
  parameter int FREQ = 32000000,
  parameter int BAUD = 115200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  glip_uart_receive_if.master        out_if,
  output logic                       error_framing,
  output logic                       error_overrun,
`ifdef GLIP_UART_RX_PARITY_EN
  output logic                       error_parity,
`endif
  output logic                       error
);

  localparam int DIV   = FREQ / (16 * BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_div_chk
      $error("glip_uart_receive: FREQ/(16*BAUD) must be at least 1");
    end
  endgenerate

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef GLIP_UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  // synchronizer
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_s;

  // oversample tick
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  // frame FSM
  logic [2:0]       state_q, state_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             s7_q, s7_d;
  logic             s8_q, s8_d;
  logic             vote;
  logic             byte_done;
  logic             fr_pulse;
  logic             ov_pulse;
  logic             par_pulse;
`ifdef GLIP_UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             err_par_q, err_par_d;
`endif

  // output side
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             err_fr_q, err_fr_d;
  logic             err_ov_q, err_ov_d;
  logic             error_q, error_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_s      = rx_s_q;
    tick      = (div_cnt_q == DIV_W'(DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // The vote is only consumed on the scnt=9 tick, where rx_s is the third sample.
  assign vote = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    byte_done = 1'b0;
    fr_pulse  = 1'b0;
    par_pulse = 1'b0;
`ifdef GLIP_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    if (tick && (state_q != IDLE)) begin
      scnt_d = scnt_q + 4'd1;
      if (scnt_q == 4'd7) s7_d = rx_s;
      if (scnt_q == 4'd8) s8_d = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          scnt_d  = 4'd0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if ((scnt_q == 4'd9) && vote) begin
            state_d = IDLE;
          end else if (scnt_q == 4'd15) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == 4'd9) shreg_d = {vote, shreg_q[7:1]};
          if (scnt_q == 4'd15) begin
            if (bit_idx_q == 3'd7) state_d = AFTER_DATA;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef GLIP_UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt_q == 4'd9) begin
            par_bad_d = ^{shreg_q, vote};
            par_pulse = ^{shreg_q, vote};
          end
          if (scnt_q == 4'd15) state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Leave on the mid-bit vote rather than waiting out the stop bit,
        // so a slightly fast transmitter does not lose the next start edge.
        if (tick && (scnt_q == 4'd9)) begin
          if (vote) begin
`ifdef GLIP_UART_RX_PARITY_EN
            byte_done = !par_bad_q;
`else
            byte_done = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            fr_pulse = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = out_valid_q & out_if.out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ov_pulse    = 1'b0;
    if (accept) out_valid_d = 1'b0;
    if (byte_done) begin
      if (!out_valid_q || accept) begin
        out_data_d  = shreg_q;
        out_valid_d = 1'b1;
      end else begin
        ov_pulse = 1'b1;
      end
    end
    err_fr_d = fr_pulse;
    err_ov_d = ov_pulse;
`ifdef GLIP_UART_RX_PARITY_EN
    err_par_d = par_pulse;
`endif
    error_d  = error_q | fr_pulse | ov_pulse | par_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      div_cnt_q   <= '0;
      state_q     <= IDLE;
      scnt_q      <= 4'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      err_fr_q    <= 1'b0;
      err_ov_q    <= 1'b0;
      error_q     <= 1'b0;
`ifdef GLIP_UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      err_par_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_fr_q    <= err_fr_d;
      err_ov_q    <= err_ov_d;
      error_q     <= error_d;
`ifdef GLIP_UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      err_par_q   <= err_par_d;
`endif
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign error_framing    = err_fr_q;
  assign error_overrun    = err_ov_q;
  assign error            = error_q;
`ifdef GLIP_UART_RX_PARITY_EN
  assign error_parity     = err_par_q;
`endif

endmodule

// File: tb/tb_glip_uart_receive.sv
// Directed bench for glip_uart_receive at DIV=1 (16 clocks per bit).
module tb_glip_uart_receive;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic error_framing, error_overrun, error;
`ifdef GLIP_UART_RX_PARITY_EN
  logic error_parity;
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  glip_uart_receive_if u_if ();

  glip_uart_receive #(.FREQ(1600000), .BAUD(100000)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .out_if        (u_if),
    .error_framing (error_framing),
    .error_overrun (error_overrun),
`ifdef GLIP_UART_RX_PARITY_EN
    .error_parity  (error_parity),
`endif
    .error         (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // monitor: counts cycles/pulses, records every accepted byte
  int vcyc = 0, fr_cnt = 0, ov_cnt = 0, par_cnt = 0;
  logic [7:0] acc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.out_valid) vcyc++;
      if (u_if.out_valid && u_if.out_ready) acc_q.push_back(u_if.out_data);
      if (error_framing) fr_cnt++;
      if (error_overrun) ov_cnt++;
`ifdef GLIP_UART_RX_PARITY_EN
      if (error_parity) par_cnt++;
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // spike_k: frame bit index (0=start) that gets a 1-clock inversion at offset 9
  // abort_cyc: frame cycle at which rst is pulsed and the frame abandoned
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int spike_k,
                            input logic par_flip, input int abort_cyc);
    logic [10:0] fb;
    int nbits;
    logic v;
    fb = '1;
    fb[0] = 1'b0;
    fb[8:1] = b;
    if (PAR_EN) begin
      fb[9]  = (^b) ^ par_flip;
      fb[10] = stop_b;
      nbits  = 11;
    end else begin
      fb[9]  = stop_b;
      nbits  = 10;
    end
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < 16; c++) begin
        if (k * 16 + c == abort_cyc) begin
          rst = 1'b1;
          cyc(1);
          rst = 1'b0;
          rx  = 1'b1;
          return;
        end
        v = fb[k];
        if (k == spike_k && c == 9) v = ~v;
        rx = v;
        cyc(1);
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; u_if.out_ready = 1'b1;
    cyc(3);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (u_if.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", u_if.out_data); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (error_framing !== 1'b0 || error_overrun !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got=%b%b exp=00", error_framing, error_overrun); end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_basic();
    int v0, a0;
    v0 = vcyc; a0 = acc_q.size();
    send_frame(8'hA5, 1'b1, -1, 1'b0, -1);
    cyc(20);
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", acc_q.size() - a0); end
    checks++; if (acc_q.size() > a0 && acc_q[acc_q.size()-1] !== 8'hA5) begin errors++;
      $display("FAIL basic_data got=%h exp=a5", acc_q[acc_q.size()-1]); end
    checks++; if (vcyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcyc - v0); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b exp=0", error); end
  endtask

  task automatic test_glitch();
    int v0, a0;
    v0 = vcyc;
    rx = 1'b0; cyc(5); rx = 1'b1; cyc(40);
    checks++; if (vcyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", vcyc - v0); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL glitch_error got=%b exp=0", error); end
    a0 = acc_q.size();
    send_frame(8'h3C, 1'b1, -1, 1'b0, -1);
    cyc(20);
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", acc_q.size() - a0); end
    checks++; if (acc_q.size() > a0 && acc_q[acc_q.size()-1] !== 8'h3C) begin errors++;
      $display("FAIL glitch_next_data got=%h exp=3c", acc_q[acc_q.size()-1]); end
  endtask

  task automatic test_framing();
    int v0, f0, a0;
    v0 = vcyc; f0 = fr_cnt;
    send_frame(8'h55, 1'b0, -1, 1'b0, -1);
    cyc(20);
    checks++; if (fr_cnt - f0 !== 1) begin errors++; $display("FAIL framing_pulse got=%0d exp=1", fr_cnt - f0); end
    checks++; if (vcyc - v0 !== 0) begin errors++; $display("FAIL framing_valid got=%0d exp=0", vcyc - v0); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL framing_sticky got=%b exp=1", error); end
    a0 = acc_q.size();
    send_frame(8'h12, 1'b1, -1, 1'b0, -1);
    cyc(20);
    checks++; if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size()-1] !== 8'h12) begin errors++;
      $display("FAIL framing_next_data got=%h exp=12", acc_q[acc_q.size()-1]); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL framing_hold got=%b exp=1", error); end
  endtask

  task automatic test_overrun();
    int o0, a0;
    o0 = ov_cnt; a0 = acc_q.size();
    u_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 1'b0, -1);
    cyc(5);
    checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h11) begin errors++;
      $display("FAIL overrun_first got=%b/%h exp=1/11", u_if.out_valid, u_if.out_data); end
    send_frame(8'h22, 1'b1, -1, 1'b0, -1);
    cyc(5);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt - o0); end
    checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h11) begin errors++;
      $display("FAIL overrun_hold got=%b/%h exp=1/11", u_if.out_valid, u_if.out_data); end
    u_if.out_ready = 1'b1;
    cyc(3);
    checks++; if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size()-1] !== 8'h11) begin errors++;
      $display("FAIL overrun_accept got=%h exp=11", acc_q[acc_q.size()-1]); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drop got=%b exp=0", u_if.out_valid); end
  endtask

  task automatic test_rst_midframe();
    int v0, f0, a0;
    v0 = vcyc; f0 = fr_cnt;
    send_frame(8'h7E, 1'b1, -1, 1'b0, 5 * 16 + 8);
    cyc(40);
    checks++; if (vcyc - v0 !== 0) begin errors++; $display("FAIL rstmid_valid got=%0d exp=0", vcyc - v0); end
    checks++; if (error !== 1'b0 || fr_cnt - f0 !== 0) begin errors++;
      $display("FAIL rstmid_error got=%b/%0d exp=0/0", error, fr_cnt - f0); end
    a0 = acc_q.size();
    send_frame(8'h81, 1'b1, -1, 1'b0, -1);
    cyc(20);
    checks++; if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size()-1] !== 8'h81) begin errors++;
      $display("FAIL rstmid_next got=%h exp=81", acc_q[acc_q.size()-1]); end
  endtask

  task automatic test_spike();
    int a0;
    a0 = acc_q.size();
    send_frame(8'hF0, 1'b1, 4, 1'b0, -1);
    cyc(20);
    checks++; if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size()-1] !== 8'hF0) begin errors++;
      $display("FAIL spike_data got=%h exp=f0", acc_q[acc_q.size()-1]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL spike_error got=%b exp=0", error); end
`ifdef GLIP_UART_RX_PARITY_EN
    begin
      int p0, v0;
      p0 = par_cnt; v0 = vcyc;
      send_frame(8'hF0, 1'b1, -1, 1'b1, -1);
      cyc(20);
      checks++; if (par_cnt - p0 !== 1) begin errors++; $display("FAIL parity_pulse got=%0d exp=1", par_cnt - p0); end
      checks++; if (vcyc - v0 !== 0) begin errors++; $display("FAIL parity_valid got=%0d exp=0", vcyc - v0); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL parity_sticky got=%b exp=1", error); end
    end
`endif
  endtask

  initial begin
    u_if.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_rst_midframe();
    test_spike();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/glip_uart_receive.md
Name: glip_uart_receive

Overview:
Serial-to-parallel UART receiver (8N1) that sits directly upstream of the UART control layer. It drives that layer's ingress byte stream (ingress_in_data/valid/ready).
- Oversamples the asynchronous rx line at 16x the baud rate and majority-votes each bit.
- Hands each received byte over a valid/ready handshake from a single-entry holding register.
- Reports framing and overrun errors; the top level ORs these into the control error.

Parameters:
FREQ, 32000000, core clock frequency in Hz.
BAUD, 115200, line baud rate.
DIV (localparam), FREQ/(16*BAUD) with integer truncation, clocks per oversample tick. Elaboration must fail if DIV < 1.

Ports:
clk  input  1  core clock
rst  input  1  reset, synchronous, active-high
rx  input  1  asynchronous serial line, idle high
out_data  output  8  received byte, valid while out_valid=1
out_valid  output  1  byte available in holding register
out_ready  input  1  consumer accepts byte when out_valid & out_ready
error_framing  output  1  one-cycle pulse on a bad stop bit
error_overrun  output  1  one-cycle pulse when a byte is dropped
error  output  1  sticky OR of both error pulses, cleared only by rst

Behaviour:
- Reset values:
  - Sync flops = 1; state = IDLE; divider and sample counters = 0.
  - out_valid = 0; out_data = 0x00.
  - error_framing = error_overrun = error = 0.
- rx passes through a 2-flop synchronizer to give rx_s; all decisions use rx_s only.
- Tick generator:
  - Free-running divider counts 0..DIV-1; tick=1 in the cycle the count equals DIV-1.
  - With DIV=1, tick is high every cycle.
- Sample counter: scnt (4 bits) increments on every tick while not IDLE and wraps 15->0.
- Bit vote: majority of rx_s captured at scnt=7, 8 and 9. The vote is decided on the tick where scnt=9.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a tick with rx_s=0, scnt<=0 and go to START.
  - START:
    - Vote at scnt=9. If the vote is 1 it is a glitch: go to IDLE, no error.
    - Otherwise stay until the tick at scnt=15, then go to DATA with bit index 0.
  - DATA:
    - Vote at scnt=9 is shifted into the shift register, LSB first.
    - At the tick with scnt=15, increment the bit index. After bit index 7, go to STOP.
  - STOP: vote at scnt=9.
    - Vote 1: byte complete, go to IDLE immediately. The state does not wait out the rest of the stop bit, which tolerates baud mismatch.
    - Vote 0: error_framing pulses, the byte is discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Byte delivery:
  - On byte completion, if out_valid=0 or (out_valid & out_ready) in that same cycle: load out_data and set out_valid=1 in the next cycle.
  - If out_valid=1 and out_ready=0: the new byte is dropped, out_data keeps the old byte, and error_overrun pulses.
- Latency: out_valid rises 1 cycle after the STOP-vote tick.
- Handshake:
  - out_valid stays high and out_data stays stable until out_valid & out_ready.
  - out_valid clears in the cycle after acceptance unless a new byte loads in that same cycle.
- error is set by either pulse and holds until rst.
- rst asserted mid-frame aborts the frame without any error. After reset the block re-synchronizes on the next falling edge (line idles high).

Optional Feature:
GLIP_UART_RX_PARITY_EN
- Defined: 8E1 framing. A PARITY state is inserted between DATA and STOP and samples the same way as a data bit.
  - If the XOR of the 8 data bits and the parity bit is not 0, the byte is discarded.
  - A new output port error_parity pulses for one cycle and also feeds the sticky error.
  - The FSM still evaluates STOP normally; a framing error in the same frame additionally pulses error_framing.
- Undefined: 8N1 framing as above; no PARITY state and no error_parity port.

Test Plan (FREQ=1600000, BAUD=100000 so DIV=1 and 16 clocks per bit; out_ready=1 unless stated):
1. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> out_valid for exactly 1 cycle, out_data=0xA5, error=0.
2. Low glitch of 5 clocks on idle rx -> FSM returns to IDLE, no out_valid, no error; a following 0x3C is received correctly.
3. Send 0x55 with stop bit held 0, then rx high -> error_framing pulses once, no out_valid, error=1 sticky; a following 0x12 is delivered and error stays 1.
4. out_ready=0; send 0x11 then 0x22 -> out_data stays 0x11 with out_valid held, error_overrun pulses at the end of 0x22. Raise out_ready -> 0x11 accepted, out_valid drops.
5. Assert rst for 1 cycle during bit 4 of 0x7E -> no output, no error. A complete 0x81 sent afterwards is received as 0x81.
6. Bit 3 of 0xF0 has a 1-clock inverted spike at sample 8 -> majority vote recovers it and out_data=0xF0. With GLIP_UART_RX_PARITY_EN, sending 0xF0 with parity bit 1 -> error_parity pulses and no out_valid.
